// File: rtl/sram_req_arbiter.sv
// Two-master to one-slave arbiter for sram-like ports.
// Port 0 is instruction fetch and port 1 is data access; data has priority.
// Once the slave has seen an address that it has not accepted, the grant stays
// locked on that master. The master id of each accepted transfer is queued so
// that every in-order response goes back to the master that issued it.
module sram_req_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned ID_W        = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic [ID_W:0]   FULL_CNT = (ID_W + 1)'(OUTSTANDING);
    localparam logic [ID_W-1:0] LAST_PTR = ID_W'(OUTSTANDING - 1);

    // Grant lock: holds the master whose address the slave has seen but not accepted
    logic                   lock_valid;
    logic                   lock_id;

    // ID FIFO: 0 = inst, 1 = data
    logic [OUTSTANDING-1:0] id_fifo;
    logic [ID_W-1:0]        wr_ptr;
    logic [ID_W-1:0]        rd_ptr;
    logic [ID_W:0]          count;

    logic                   full;
    logic                   grant;
    logic                   push;
    logic                   pop;
    logic                   head_id;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign head_id = id_fifo[rd_ptr];

    // Grant selection: a held lock wins, otherwise data before inst
    always_comb begin
        grant = 1'b0;
        if (lock_valid) begin
            grant = lock_id;
        end else if (data_req) begin
            grant = 1'b1;
        end else if (inst_req) begin
            grant = 1'b0;
        end
    end

    // Slave request and payload mux; handshakes are gated off while in reset
    always_comb begin
        mem_req   = resetn & ~full & (grant ? data_req : inst_req);
        mem_wr    = grant ? data_wr    : inst_wr;
        mem_size  = grant ? data_size  : inst_size;
        mem_wstrb = grant ? data_wstrb : inst_wstrb;
        mem_addr  = grant ? data_addr  : inst_addr;
        mem_wdata = grant ? data_wdata : inst_wdata;
    end

    // Accept and response routing; a data_ok with nothing queued is dropped
    always_comb begin
        push         = mem_req & mem_addr_ok;
        pop          = resetn & mem_data_ok & (count != '0);
        inst_addr_ok = push & ~grant;
        data_addr_ok = push & grant;
        inst_data_ok = pop & ~head_id;
        data_data_ok = pop & head_id;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        busy         = (count != '0);
    end

    // Lock register: set on a stalled address phase, released on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
        end else if (push) begin
            lock_valid <= 1'b0;
        end else if (mem_req) begin
            lock_valid <= 1'b1;
            lock_id    <= grant;
        end
    end

    // ID FIFO storage and pointers; push and pop may happen in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one sram-like slave port between the instruction-fetch master (port 0, inst_sram) and the data-access master (port 1, data_sram).
- Sits between the CPU core and the memory bridge.
- Arbitrates the address phase and tracks outstanding transactions in order, so each data_ok/rdata is routed back to the master that issued it.

Parameters:
- OUTSTANDING, 2: maximum accepted-but-unanswered requests; depth of the ID FIFO; power of two, at least 1.
- ID_W, 1: width of the FIFO pointers, equal to log2(OUTSTANDING), minimum 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_req/inst_wr/inst_size/inst_wstrb/inst_addr/inst_wdata  in  1/1/2/4/32/32  port-0 request.
- inst_addr_ok/inst_data_ok  out  1/1  port-0 handshakes.
- inst_rdata  out  32  port-0 read data.
- data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata  in  1/1/2/4/32/32  port-1 request.
- data_addr_ok/data_data_ok  out  1/1  port-1 handshakes.
- data_rdata  out  32  port-1 read data.
- mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata  out  1/1/2/4/32/32  slave request.
- mem_addr_ok/mem_data_ok  in  1/1  slave handshakes.
- mem_rdata  in  32  slave read data.
- busy  out  1  high while any transaction is outstanding.

Behaviour:
- Protocol: a transfer is accepted in the cycle where req and addr_ok are both high; a response returns on data_ok; responses are in order; masters hold req and payload stable until addr_ok.
- Registered state:
  - lock_valid, lock_id: grant lock.
  - ID FIFO: OUTSTANDING entries of 1 bit, wr_ptr, rd_ptr, count (0..OUTSTANDING).
- Reset (resetn low, asynchronous): lock_valid=0, lock_id=0, pointers=0, count=0. All outputs then evaluate to 0: mem_req=0, all addr_ok/data_ok=0, busy=0.
- full = (count == OUTSTANDING). While full, mem_req=0 and no addr_ok is given to either master.
- Grant, combinational:
  - if lock_valid, grant = lock_id;
  - else if data_req, grant = 1 (data has priority);
  - else if inst_req, grant = 0.
  - mem_req = ~full & (request of the granted port).
  - mem_* payload is muxed from the granted port.
- Lock:
  - Set when mem_req=1 and mem_addr_ok=0: lock_valid<=1, lock_id<=grant.
  - Cleared in the cycle mem_req & mem_addr_ok.
  - While locked, the other port is not granted even if it requests. This keeps the slave's pending address stable.
- Accept: when mem_req & mem_addr_ok, the granted port's addr_ok=1 combinationally in the same cycle, and the FIFO pushes the grant id.
- Response:
  - When mem_data_ok & count!=0, the FIFO head id selects which of inst_data_ok/data_data_ok is 1, and the FIFO pops.
  - mem_rdata is driven unchanged to both inst_rdata and data_rdata.
  - Responses for writes pop the FIFO like reads.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A pop while full frees a slot only from the next cycle; mem_req stays 0 in that cycle.
- mem_data_ok with count==0 is spurious: ignored, no data_ok is asserted, state is unchanged.
- Pointers wrap modulo OUTSTANDING.
- busy = (count != 0).
- Zero added latency: address phase and response pass through combinationally.
- A reset mid-transaction discards all outstanding IDs. Any late mem_data_ok after reset is spurious and is ignored.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0x1c000000; mem_addr_ok=1 in the same cycle; mem_data_ok=1 with mem_rdata=0x02800c0c two cycles later.
  -> mem_addr=0x1c000000, inst_addr_ok=1, then inst_data_ok=1, inst_rdata=0x02800c0c, data_data_ok=0, busy 1 then 0.
- Contention: inst_req and data_req both rise, data_addr=0x1c010000 with wr=1, wstrb=0xF.
  -> data is granted first, with mem_wr=1 and mem_addr=0x1c010000. Inst is accepted in the following cycle. Responses in order give data_data_ok and then inst_data_ok.
- Lock: inst_req alone, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 2.
  -> mem_addr stays the inst address for all 3 cycles. Inst is accepted on addr_ok; data is granted in the next cycle.
- Full: OUTSTANDING=2, two accepted fetches, no data_ok, third inst_req.
  -> mem_req=0 and inst_addr_ok=0. After one mem_data_ok, mem_req=1 from the next cycle.
- Spurious and reset: mem_data_ok pulse with count=0 -> both data_ok=0. Assert resetn=0 with one transaction outstanding -> busy=0 and mem_req=0 immediately, without waiting for a clock edge.
